// File: rtl/int_sync_gateway_arbiter.sv
// Interrupt sink: per-source synchronizers, level/edge gateways, round-robin claim port with completions.
// Latency: input-to-claim SYNC_DEPTH+1 cycles; an offer holds stable until claim_ready, with at least one idle cycle between claims.
module int_sync_gateway_arbiter #(
  parameter int N_SRC      = 4,
  parameter int SYNC_DEPTH = 3,
  parameter int ID_W       = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_async,
  input  logic [N_SRC-1:0] cfg_enable,
  input  logic [N_SRC-1:0] cfg_edge,
  output logic             claim_valid,
  output logic [ID_W-1:0]  claim_id,
  input  logic             claim_ready,
  input  logic             complete_valid,
  input  logic [ID_W-1:0]  complete_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service,
  output logic             irq
);

  typedef enum logic [1:0] {
    GW_IDLE  = 2'd0,
    GW_PEND  = 2'd1,
    GW_INSVC = 2'd2
  } gw_state_e;

  logic [N_SRC-1:0] sync_q [SYNC_DEPTH];
  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] trig;

  gw_state_e        gw_q [N_SRC];
  gw_state_e        gw_d [N_SRC];
  logic [N_SRC-1:0] edge_seen_q;
  logic [N_SRC-1:0] edge_seen_d;
  logic [N_SRC-1:0] claim_hit;
  logic [N_SRC-1:0] comp_hit;

  logic             hs;
  logic [ID_W-1:0]  ptr_q;
  logic [N_SRC-1:0] cand;
  logic             hi_vld;
  logic [ID_W-1:0]  hi_id;
  logic [ID_W-1:0]  lo_id;
  logic [ID_W-1:0]  pick_id;

  // Synchronizer chain plus one history flop for rising-edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SYNC_DEPTH; k++) begin
        sync_q[k] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= int_async;
      for (int k = 1; k < SYNC_DEPTH; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= s;
    end
  end

  assign s    = sync_q[SYNC_DEPTH-1];
  assign rise = s & ~prev_q;
  assign trig = cfg_enable & ((cfg_edge & rise) | (~cfg_edge & s));
  assign hs   = claim_valid & claim_ready;

  // Gateway state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SRC; i++) begin
        gw_q[i] <= GW_IDLE;
      end
      edge_seen_q <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        gw_q[i] <= gw_d[i];
      end
      edge_seen_q <= edge_seen_d;
    end
  end

  // Gateway next-state; a rise coinciding with the completion counts as a remembered edge.
  always_comb begin
    edge_seen_d = edge_seen_q;
    claim_hit   = '0;
    comp_hit    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      gw_d[i]      = gw_q[i];
      claim_hit[i] = hs && (claim_id == ID_W'(i));
      comp_hit[i]  = complete_valid && (complete_id == ID_W'(i));
      case (gw_q[i])
        GW_IDLE: begin
          if (trig[i]) gw_d[i] = GW_PEND;
        end
        GW_PEND: begin
          if (claim_hit[i]) gw_d[i] = GW_INSVC;
        end
        GW_INSVC: begin
          if (comp_hit[i]) begin
            gw_d[i]        = (edge_seen_q[i] || (trig[i] && cfg_edge[i])) ? GW_PEND : GW_IDLE;
            edge_seen_d[i] = 1'b0;
          end else if (trig[i] && cfg_edge[i]) begin
            edge_seen_d[i] = 1'b1;
          end
        end
        default: gw_d[i] = GW_IDLE;
      endcase
    end
  end

  // Gateway outputs decoded straight from the state registers.
  always_comb begin
    pending    = '0;
    in_service = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pending[i]    = (gw_q[i] == GW_PEND);
      in_service[i] = (gw_q[i] == GW_INSVC);
    end
  end

  assign irq  = |pending;
  assign cand = pending & cfg_enable;

  // Round-robin pick: lowest candidate above ptr, else lowest candidate overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int j = N_SRC - 1; j >= 0; j--) begin
      if (cand[j]) begin
        lo_id = ID_W'(j);
        if (ID_W'(j) > ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(j);
        end
      end
    end
    pick_id = hi_vld ? hi_id : lo_id;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      claim_valid <= 1'b0;
      claim_id    <= '0;
      ptr_q       <= ID_W'(N_SRC - 1);
    end else if (claim_valid) begin
      if (claim_ready) begin
        claim_valid <= 1'b0;
        ptr_q       <= claim_id;
      end
    end else if (|cand) begin
      claim_valid <= 1'b1;
      claim_id    <= pick_id;
    end
  end

endmodule

// File: doc/int_sync_gateway_arbiter.md
Name: int_sync_gateway_arbiter

Overview:
Interrupt-sink controller for the async interrupt crossing. It synchronizes N_SRC asynchronous interrupt lines with per-source synchronizer chains and runs a per-source gateway (level/edge, pending, in-service). A round-robin arbiter then presents one claim at a time to the consumer over a valid/ready claim port. It accepts completions that return sources to idle, and sits between the async interrupt bundle and the local interrupt consumer (PLIC/core glue).

Parameters:
N_SRC, 4, number of interrupt sources (1..32)
SYNC_DEPTH, 3, synchronizer flops per source (>=2)
ID_W, 2, width of source id; must equal max(1, ceil(log2(N_SRC)))

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
int_async  input  N_SRC  raw asynchronous interrupt lines
cfg_enable  input  N_SRC  per-source enable (synchronous to clock)
cfg_edge  input  N_SRC  1 = rising-edge triggered, 0 = level triggered
claim_valid  output  1  a claim is offered
claim_id  output  ID_W  offered source id
claim_ready  input  1  consumer accepts offer
complete_valid  input  1  consumer finished servicing complete_id
complete_id  input  ID_W  source being completed
pending  output  N_SRC  per-source PENDING state
in_service  output  N_SRC  per-source IN_SERVICE state
irq  output  1  OR of pending (registered-state derived, no input paths)

Behaviour:
- Reset: while reset low, all synchronizer flops, edge-history flops, gateway states (IDLE), edge_seen bits, claim_valid=0, claim_id=0 and the RR pointer (=N_SRC-1) are cleared asynchronously. All outputs are 0. Release takes effect at the next rising edge. Reset mid-claim drops the offer and all state.
- Sync: s[i] = int_async[i] after SYNC_DEPTH flops. prev[i] registers s[i]. rise[i] = s[i] & ~prev[i].
- Gateway per source, states IDLE / PENDING / IN_SERVICE:
  - IDLE -> PENDING when cfg_enable[i] & (cfg_edge[i] ? rise[i] : s[i]).
  - PENDING -> IN_SERVICE on claim handshake (claim_valid & claim_ready) with claim_id==i.
  - IN_SERVICE -> (edge_seen[i] ? PENDING : IDLE) on complete_valid with complete_id==i. edge_seen[i] is cleared on that edge.
  - Edge source: a rise while PENDING is coalesced (dropped). A rise while IN_SERVICE sets edge_seen[i] (one deep).
  - Level source: stays pending-capable while s high. After a complete it re-enters PENDING on the following cycle if s still high.
  - Deasserting cfg_enable blocks IDLE->PENDING and arbitration candidacy. It does not clear PENDING or IN_SERVICE.
  - A complete for a source not IN_SERVICE, or with id >= N_SRC, is ignored.
- Arbiter / claim port:
  - When claim_valid=0, candidates = PENDING & cfg_enable. If any, the next edge sets claim_valid=1 and claim_id = first candidate at or after ptr+1, wrapping modulo N_SRC.
  - While claim_valid=1 and claim_ready=0: claim_id is held stable and claim_valid is not withdrawn, even if the source is disabled.
  - On handshake: claim_valid -> 0, ptr <- claim_id, source -> IN_SERVICE. The next offer is at the earliest one cycle later, so claim_valid is low for at least one cycle between claims.
  - Only one claim is outstanding on the port. Multiple sources may be IN_SERVICE at once.
- Latency: an int_async rise sampled at edge E gives s high after edge E+SYNC_DEPTH-1, PENDING after E+SYNC_DEPTH, and claim_valid after E+SYNC_DEPTH+1 (port idle). Input-to-claim is SYNC_DEPTH+1 cycles.
- Simultaneous events:
  - Handshake and complete in the same cycle on different ids: both take effect.
  - Complete and a rise on the same IN_SERVICE edge source: goes to PENDING.
  - Complete for the id being offered: ignored, since that source is PENDING, not IN_SERVICE.
- All outputs are driven from registers, except irq (OR of state registers).

Test Plan:
- Reset then hold reset low with int_async=4'b1111 -> all outputs 0. Release, level mode, enable=4'hF -> claim_valid=1, claim_id=0 at cycle 4 after first sample; pending=4'hF.
- Level src0 high, claim_ready=1 continuously -> ids 0 granted, complete 0, src0 still high -> PENDING again the next cycle and re-claimed after src1..3 per RR order 1,2,3,0.
- Edge src2: pulse twice 10 cycles apart while IN_SERVICE -> on complete_id=2, state returns to PENDING once (edge_seen). A third pulse while PENDING is coalesced: exactly one further claim.
- claim_ready=0 for 20 cycles with offer id=1, toggle cfg_enable[1] low -> claim_valid/claim_id=1 stable throughout. Ready=1 -> handshake, in_service=4'b0010.
- Bogus complete_id=3 with src3 IDLE, and complete_id=1 while src1 only PENDING -> no state change.
- Assert reset mid-offer (claim_valid=1, in_service=4'b0101) -> all outputs 0 immediately (asynchronous), RR restarts at id 0 after release.
